// File: rtl/ram64_rd_pkg.sv
// Shared definitions for the 64x8 LUTRAM stream reader: FSM encoding and default widths.
package ram64_rd_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/ram64_rd_oreg.sv
// Output stage of the stream reader: captures the async RAM word and last flag,
// holds them while the consumer stalls, and drops valid after the final handshake.
module ram64_rd_oreg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              cap_last,
  output logic [DATA_W-1:0] data,
  output logic              last,
  output logic              valid
);

  logic [DATA_W-1:0] data_p1;
  logic              last_p1;
  logic              vld_p1;

  // Output register stage: load replaces the word, clear retires it, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1 <= '0;
      last_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else if (load) begin
      data_p1 <= cap_data;
      last_p1 <= cap_last;
      vld_p1  <= 1'b1;
    end else if (clear) begin
      last_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end
  end

  assign data  = data_p1;
  assign last  = last_p1;
  assign valid = vld_p1;

endmodule

// File: rtl/ram64m8_stream_reader.sv
// Burst read engine for a 64x8 async-read LUTRAM: takes (address, length) commands,
// walks the RAM read address and streams the words out with valid/ready and a last flag.
module ram64m8_stream_reader
  import ram64_rd_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_STEP = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [ADDR_W-1:0] CMD_LEN,
  output logic [ADDR_W-1:0] RD_ADDR,
  input  logic [DATA_W-1:0] RD_DATA,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic [DATA_W-1:0] M_DATA,
  output logic              M_LAST,
  output logic              BUSY
);

  localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(ADDR_STEP);
  localparam logic [ADDR_W-1:0] ONE_V  = ADDR_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] cnt;
  logic              accept;
  logic              load;
  logic              clear;

  // Ready is masked by reset so no command can slip in while the engine is being cleared.
  assign CMD_READY = (state == IDLE) && !RST;
  assign BUSY      = (state != IDLE);
  assign accept    = CMD_VALID && CMD_READY;
  assign RD_ADDR   = ptr;

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and output-register control; a load happens whenever the output slot is free.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    clear     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!M_VALID || M_READY) begin
          load = 1'b1;
          if (cnt == '0) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (M_VALID && M_READY) begin
          clear     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Address pointer and remaining-beat counter; both freeze while the output stalls.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr <= '0;
      cnt <= '0;
    end else if (accept) begin
      ptr <= CMD_ADDR;
      cnt <= CMD_LEN;
    end else if (load) begin
      ptr <= ptr + STEP_V;
      cnt <= cnt - ONE_V;
    end
  end

  // Stage p0 -> p1: RAM read data registered into the stream output.
  ram64_rd_oreg #(
    .DATA_W(DATA_W)
  ) u_oreg (
    .clk      (CLK),
    .rst      (RST),
    .load     (load),
    .clear    (clear),
    .cap_data (RD_DATA),
    .cap_last (cnt == '0),
    .data     (M_DATA),
    .last     (M_LAST),
    .valid    (M_VALID)
  );

endmodule

// File: tb/tb_ram64m8_stream_reader.sv
// Self-checking bench for ram64m8_stream_reader with a 64x8 LUTRAM model (word[i] = i ^ 8'h5A).
module tb_ram64m8_stream_reader;

  logic       CLK;
  logic       RST;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [5:0] CMD_ADDR;
  logic [5:0] CMD_LEN;
  logic [5:0] RD_ADDR;
  logic [7:0] RD_DATA;
  logic       M_VALID;
  logic       M_READY;
  logic [7:0] M_DATA;
  logic       M_LAST;
  logic       BUSY;

  logic [7:0] mem [64];
  logic [7:0] got_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  ram64m8_stream_reader dut (
    .CLK       (CLK),
    .RST       (RST),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .CMD_ADDR  (CMD_ADDR),
    .CMD_LEN   (CMD_LEN),
    .RD_ADDR   (RD_ADDR),
    .RD_DATA   (RD_DATA),
    .M_VALID   (M_VALID),
    .M_READY   (M_READY),
    .M_DATA    (M_DATA),
    .M_LAST    (M_LAST),
    .BUSY      (BUSY)
  );

  assign RD_DATA = mem[RD_ADDR];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_burst(input logic [5:0] addr, input logic [5:0] len, input bit rnd,
                           input string tag);
    int         hs;
    int         cyc;
    bit         seen;
    bit         done;
    bit         stall_prev;
    logic [7:0] pd;
    logic       pl;
    logic [5:0] ea;
    got_q.delete();
    @(posedge CLK); #1;
    CMD_VALID = 1'b1;
    CMD_ADDR  = addr;
    CMD_LEN   = len;
    M_READY   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge CLK);
    check_val({tag, "_cmd_ready"}, CMD_READY, 1);
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
    hs = 0; cyc = 0; seen = 0; done = 0; stall_prev = 0; pd = '0; pl = 1'b0;
    while (!done && cyc < 600) begin
      @(negedge CLK);
      cyc++;
      check_val($sformatf("%s_cmd_ready_busy_c%0d", tag, cyc), CMD_READY, 0);
      if (!seen && M_VALID) begin
        seen = 1;
        check_val({tag, "_latency"}, cyc, 2);
      end
      if (BUSY) begin
        ea = addr + 6'(hs) + {5'b0, M_VALID};
        check_val($sformatf("%s_rd_addr_c%0d", tag, cyc), RD_ADDR, ea);
      end
      if (stall_prev) begin
        check_val($sformatf("%s_hold_valid_c%0d", tag, cyc), M_VALID, 1);
        check_val($sformatf("%s_hold_data_c%0d", tag, cyc), M_DATA, pd);
        check_val($sformatf("%s_hold_last_c%0d", tag, cyc), M_LAST, pl);
      end
      if (M_VALID && M_READY) begin
        ea = addr + 6'(hs);
        check_val($sformatf("%s_data_b%0d", tag, hs), M_DATA, mem[ea]);
        check_val($sformatf("%s_last_b%0d", tag, hs), M_LAST, (hs == int'(len)) ? 1 : 0);
        got_q.push_back(M_DATA);
        if (hs == int'(len)) done = 1;
        hs++;
      end
      stall_prev = M_VALID && !M_READY;
      pd = M_DATA;
      pl = M_LAST;
      @(posedge CLK); #1;
      if (rnd) M_READY = 1'($urandom_range(0, 1));
    end
    check_val({tag, "_beats"}, hs, int'(len) + 1);
    M_READY = 1'b1;
    @(negedge CLK);
    check_val({tag, "_post_valid"}, M_VALID, 0);
    check_val({tag, "_post_last"}, M_LAST, 0);
    check_val({tag, "_post_busy"}, BUSY, 0);
    check_val({tag, "_post_cmd_ready"}, CMD_READY, 1);
  endtask

  initial begin
    logic [7:0] exp_t2 [4];
    logic [7:0] exp_t3 [4];
    int         hs;
    int         cyc;

    for (int i = 0; i < 64; i++) mem[i] = 8'(i) ^ 8'h5A;
    exp_t2 = '{8'h4A, 8'h4B, 8'h48, 8'h49};
    exp_t3 = '{8'h64, 8'h65, 8'h5A, 8'h5B};

    RST = 1'b1; CMD_VALID = 1'b0; CMD_ADDR = '0; CMD_LEN = '0; M_READY = 1'b0;

    // 1: reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_val("rst_m_valid", M_VALID, 0);
    check_val("rst_m_data", M_DATA, 0);
    check_val("rst_m_last", M_LAST, 0);
    check_val("rst_busy", BUSY, 0);
    check_val("rst_rd_addr", RD_ADDR, 0);
    check_val("rst_cmd_ready", CMD_READY, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check_val("rst_release_cmd_ready", CMD_READY, 1);

    // 2: basic 4-beat burst at full throughput
    run_burst(6'h10, 6'd3, 1'b0, "t2");
    for (int i = 0; i < 4; i++)
      check_val($sformatf("t2_tbl_b%0d", i), (got_q.size() > i) ? got_q[i] : 8'hxx, exp_t2[i]);

    // 3: wrap-around at the top of the RAM
    run_burst(6'h3E, 6'd3, 1'b0, "t3");
    for (int i = 0; i < 4; i++)
      check_val($sformatf("t3_tbl_b%0d", i), (got_q.size() > i) ? got_q[i] : 8'hxx, exp_t3[i]);

    // 4: random backpressure
    run_burst(6'h08, 6'd15, 1'b1, "t4");

    // 5: full-depth burst
    run_burst(6'h20, 6'd63, 1'b0, "t5");
    check_val("t5_final_word", (got_q.size() == 64) ? got_q[63] : 8'hxx, 8'h45);

    // 6: reset in the middle of a burst, then a single-beat command
    @(posedge CLK); #1;
    CMD_VALID = 1'b1; CMD_ADDR = 6'h00; CMD_LEN = 6'd10; M_READY = 1'b1;
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
    hs = 0; cyc = 0;
    while (hs < 2 && cyc < 20) begin
      @(negedge CLK);
      cyc++;
      if (M_VALID && M_READY) hs++;
    end
    check_val("t6_pre_reset_beats", hs, 2);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check_val("t6_rst_valid", M_VALID, 0);
    check_val("t6_rst_last", M_LAST, 0);
    check_val("t6_rst_busy", BUSY, 0);
    check_val("t6_rst_cmd_ready", CMD_READY, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check_val($sformatf("t6_no_beat_c%0d", i), M_VALID, 0);
    end
    run_burst(6'h05, 6'd0, 1'b0, "t6b");
    check_val("t6b_word", (got_q.size() == 1) ? got_q[0] : 8'hxx, 8'h5F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
